// File: rtl/cordic_pkg.sv
// Shared CORDIC definitions: FSM state encoding and the arctangent table
// generator. The angle unit is pi/2^n_frac, so pi/4 is exactly 2^(n_frac-2).
package cordic_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_CALC   = 2'b01,
    ST_OUTPUT = 2'b10
  } state_e;

  localparam int          ATAN_FB = 60;
  localparam logic [127:0] PI_FX  = 128'h3243F6A8885A308D;  // pi * 2^60, truncated

  // floor(atan(2^-i) * 2^n_frac / pi), valid for n_frac up to ~40.
  // The atan Taylor series is summed in 2^-60 fixed point; the truncation
  // error is far below one output LSB.
  function automatic logic [31:0] atan_angle(input int n_frac, input int i);
    logic [127:0] acc;
    logic [127:0] term;
    if (i == 0) begin
      return (n_frac >= 2) ? (32'd1 << (n_frac - 2)) : 32'd0;
    end
    acc = '0;
    for (int k = 0; k < 32; k++) begin
      term = (128'd1 << ATAN_FB) >> (i * (2 * k + 1));
      term = term / 128'(2 * k + 1);
      if (k % 2 == 0) acc = acc + term;
      else            acc = acc - term;
    end
    return 32'((acc << n_frac) / PI_FX);
  endfunction

endpackage

// File: rtl/cordic_micro_rotation.sv
// One CORDIC micro-rotation. It is purely combinational; every register
// lives in the iterating top.
module cordic_micro_rotation
  import cordic_pkg::*;
#(
  parameter int W  = 8,
  parameter int SW = 3
) (
  input  logic signed [W-1:0]  x,
  input  logic signed [W-1:0]  y,
  input  logic signed [W-1:0]  z,
  input  logic                 mode,
  input  logic        [SW-1:0] shift,
  input  logic signed [W-1:0]  angle,
  output logic signed [W-1:0]  x_n,
  output logic signed [W-1:0]  y_n,
  output logic signed [W-1:0]  z_n
);

  logic signed [W-1:0] xs, ys;
  logic                d_pos;

  always_comb begin
    xs = x >>> shift;
    ys = y >>> shift;
    // In rotation mode, steer z toward 0. In vectoring mode, steer y toward 0.
    d_pos = mode ? y[W-1] : ~z[W-1];
    if (d_pos) begin
      x_n = x - ys;
      y_n = y + xs;
      z_n = z - angle;
    end else begin
      x_n = x + ys;
      y_n = y - xs;
      z_n = z + angle;
    end
  end

endmodule

// File: rtl/cordic_iterative_mode.sv
// Iterative CORDIC engine with rotation and vectoring modes. It applies one
// micro-rotation per clock and presents a one-cycle result strobe in OUTPUT.
module cordic_iterative_mode
  import cordic_pkg::*;
#(
  parameter int N_FRAC     = 7,
  parameter int ITERATIONS = 6
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [N_FRAC:0] x_i,
  input  logic [N_FRAC:0] y_i,
  input  logic [N_FRAC:0] z_i,
  input  logic            mode_i,
  input  logic            data_in_valid_strobe_i,
  output logic            ready_o,
  output logic [N_FRAC:0] x_o,
  output logic [N_FRAC:0] y_o,
  output logic [N_FRAC:0] z_o,
  output logic            data_out_valid_strobe_o,
  output logic            busy_o
);

  localparam int W  = N_FRAC + 1;
  localparam int CW = (ITERATIONS > 1) ? $clog2(ITERATIONS) : 1;
  localparam logic [CW-1:0] LAST = CW'(ITERATIONS - 1);

  state_e              state, state_nxt;
  logic [CW-1:0]       cnt;
  logic signed [W-1:0] x_r, y_r, z_r;
  logic signed [W-1:0] x_n, y_n, z_n;
  logic                mode_r;
  logic                capture, last_iter;
  logic [ITERATIONS-1:0][W-1:0] angle_tbl;
  logic [W-1:0]        angle;

  for (genvar g = 0; g < ITERATIONS; g++) begin : g_atab
    assign angle_tbl[g] = W'(atan_angle(N_FRAC, g));
  end
  assign angle = angle_tbl[cnt];

  assign ready_o                 = (state == ST_IDLE) || (state == ST_OUTPUT);
  assign busy_o                  = (state == ST_CALC);
  assign data_out_valid_strobe_o = (state == ST_OUTPUT);
  assign capture                 = data_in_valid_strobe_i & ready_o;
  assign last_iter               = busy_o && (cnt == LAST);

  cordic_micro_rotation #(.W(W), .SW(CW)) u_rot (
    .x     (x_r),
    .y     (y_r),
    .z     (z_r),
    .mode  (mode_r),
    .shift (cnt),
    .angle (angle),
    .x_n   (x_n),
    .y_n   (y_n),
    .z_n   (z_n)
  );

  always_comb begin
    state_nxt = ST_IDLE;
    case (state)
      ST_IDLE:   state_nxt = capture ? ST_CALC : ST_IDLE;
      ST_CALC:   state_nxt = last_iter ? ST_OUTPUT : ST_CALC;
      ST_OUTPUT: state_nxt = capture ? ST_CALC : ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      x_r    <= '0;
      y_r    <= '0;
      z_r    <= '0;
      mode_r <= 1'b0;
      x_o    <= '0;
      y_o    <= '0;
      z_o    <= '0;
    end else begin
      state <= state_nxt;
      if (capture) begin
        cnt    <= '0;
        x_r    <= x_i;
        y_r    <= y_i;
        z_r    <= z_i;
        mode_r <= mode_i;
      end else if (busy_o) begin
        cnt <= cnt + 1'b1;
        x_r <= x_n;
        y_r <= y_n;
        z_r <= z_n;
      end
      // Results change only on the final micro-rotation and hold until the next one.
      if (last_iter) begin
        x_o <= x_n;
        y_o <= y_n;
        z_o <= z_n;
      end
    end
  end

endmodule

// File: tb/tb_cordic_iterative_mode.sv
// Scoreboard bench for cordic_iterative_mode (N_FRAC=7, ITERATIONS=6).
module tb_cordic_iterative_mode;

  localparam int N_FRAC     = 7;
  localparam int ITERATIONS = 6;
  localparam int W          = N_FRAC + 1;
  localparam int LAT        = ITERATIONS + 1;
  localparam int N_RAND     = 2000;
  localparam int ATAB [0:ITERATIONS-1] = '{32, 18, 9, 5, 2, 1};

  typedef struct packed {
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic [W-1:0] z;
  } res_t;

  logic         clk_i = 1'b0;
  logic         rst_i = 1'b0;
  logic [W-1:0] x_i = '0, y_i = '0, z_i = '0;
  logic         mode_i = 1'b0;
  logic         data_in_valid_strobe_i = 1'b0;
  logic         ready_o, data_out_valid_strobe_o, busy_o;
  logic [W-1:0] x_o, y_o, z_o;

  res_t exp_q[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  always #5 clk_i = ~clk_i;

  cordic_iterative_mode #(.N_FRAC(N_FRAC), .ITERATIONS(ITERATIONS)) dut (
    .clk_i                   (clk_i),
    .rst_i                   (rst_i),
    .x_i                     (x_i),
    .y_i                     (y_i),
    .z_i                     (z_i),
    .mode_i                  (mode_i),
    .data_in_valid_strobe_i  (data_in_valid_strobe_i),
    .ready_o                 (ready_o),
    .x_o                     (x_o),
    .y_o                     (y_o),
    .z_o                     (z_o),
    .data_out_valid_strobe_o (data_out_valid_strobe_o),
    .busy_o                  (busy_o)
  );

  function automatic int wrap(input int v);
    logic signed [W-1:0] t;
    t = v[W-1:0];
    return int'(t);
  endfunction

  function automatic res_t model(input logic signed [W-1:0] xa, ya, za, input logic m);
    int x, y, z, xn, yn, zn, d;
    res_t r;
    x = xa; y = ya; z = za;
    for (int i = 0; i < ITERATIONS; i++) begin
      if (m) d = (y < 0) ? 1 : -1;
      else   d = (z >= 0) ? 1 : -1;
      xn = wrap(x - d * (y >>> i));
      yn = wrap(y + d * (x >>> i));
      zn = wrap(z - d * ATAB[i]);
      x = xn; y = yn; z = zn;
    end
    r.x = x[W-1:0];
    r.y = y[W-1:0];
    r.z = z[W-1:0];
    return r;
  endfunction

  // Drive one operand and wait until it is accepted. Returns #1 after the capture edge.
  task automatic issue(input logic [W-1:0] xa, ya, za, input logic ma);
    int g = 0;
    x_i = xa; y_i = ya; z_i = za; mode_i = ma;
    data_in_valid_strobe_i = 1'b1;
    while (ready_o !== 1'b1 && g < 50) begin
      @(posedge clk_i); #1;
      g++;
    end
    @(posedge clk_i); #1;
    data_in_valid_strobe_i = 1'b0;
    exp_q.push_back(model(xa, ya, za, ma));
  endtask

  // lat = index of the rising edge after capture that samples the strobe high; -1 on timeout.
  task automatic wait_strobe(output int lat);
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      if (data_out_valid_strobe_o === 1'b1) begin
        lat = k;
        break;
      end
      @(posedge clk_i); #1;
    end
  endtask

  task automatic test_reset;
    #2;
    n_chk++; if (ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", ready_o); end
    n_chk++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy_o); end
    n_chk++; if (data_out_valid_strobe_o !== 1'b0) begin n_fail++; $display("FAIL reset_strobe: got %b want 0", data_out_valid_strobe_o); end
    n_chk++; if ({x_o, y_o, z_o} !== '0) begin n_fail++; $display("FAIL reset_outputs: got %h want 0", {x_o, y_o, z_o}); end
    @(posedge clk_i); #3;
    rst_i = 1'b1;
    @(posedge clk_i); #1;
  endtask

  // Directed vectors with hand-derived results: unit rotation, pi/2 rotation, and vectoring at 45 degrees.
  task automatic test_directed;
    logic [W-1:0] tx [3] = '{8'd64, 8'd32, 8'd32};
    logic [W-1:0] ty [3] = '{8'd0,  8'd0,  8'd32};
    logic [W-1:0] tz [3] = '{8'd0,  8'd64, 8'd0};
    logic         tm [3] = '{1'b0,  1'b0,  1'b1};
    res_t         th [3] = '{{8'd106, 8'hFE, 8'hFF}, {8'hFC, 8'd52, 8'hFF}, {8'd76, 8'hFF, 8'd33}};
    int   lat;
    res_t e;
    for (int t = 0; t < 3; t++) begin
      issue(tx[t], ty[t], tz[t], tm[t]);
      n_chk++; if (busy_o !== 1'b1 || ready_o !== 1'b0) begin n_fail++; $display("FAIL dir%0d_calc_flags: got busy=%b ready=%b want 1/0", t, busy_o, ready_o); end
      wait_strobe(lat);
      n_chk++; if (lat !== LAT) begin n_fail++; $display("FAIL dir%0d_latency: got %0d want %0d", t, lat, LAT); end
      e = exp_q.pop_front();
      n_chk++; if ({x_o, y_o, z_o} !== e) begin n_fail++; $display("FAIL dir%0d_model: got %h want %h", t, {x_o, y_o, z_o}, e); end
      n_chk++; if ({x_o, y_o, z_o} !== th[t]) begin n_fail++; $display("FAIL dir%0d_hand: got %h want %h", t, {x_o, y_o, z_o}, th[t]); end
      @(posedge clk_i); #1;
      n_chk++; if (data_out_valid_strobe_o !== 1'b0) begin n_fail++; $display("FAIL dir%0d_strobe_width: got %b want 0", t, data_out_valid_strobe_o); end
      repeat (3) @(posedge clk_i);
      #1;
      n_chk++; if ({x_o, y_o, z_o} !== e) begin n_fail++; $display("FAIL dir%0d_hold: got %h want %h", t, {x_o, y_o, z_o}, e); end
    end
  endtask

  // Valid held high throughout: requests during CALC are ignored, and the one seen in OUTPUT is captured immediately.
  task automatic test_back_to_back;
    res_t ea, eb;
    int   lat;
    bit   busy_ok = 1'b1;
    x_i = 8'd50; y_i = 8'd20; z_i = 8'd10; mode_i = 1'b0;
    data_in_valid_strobe_i = 1'b1;
    @(posedge clk_i); #1;
    exp_q.push_back(model(8'd50, 8'd20, 8'd10, 1'b0));
    x_i = 8'd40; y_i = 8'hE0; z_i = 8'd5; mode_i = 1'b1;
    for (int k = 1; k < LAT; k++) begin
      if (busy_o !== 1'b1) busy_ok = 1'b0;
      @(posedge clk_i); #1;
    end
    n_chk++; if (!busy_ok) begin n_fail++; $display("FAIL b2b_busy_in_calc: got not-busy want busy"); end
    n_chk++; if (data_out_valid_strobe_o !== 1'b1) begin n_fail++; $display("FAIL b2b_first_strobe: got %b want 1", data_out_valid_strobe_o); end
    ea = exp_q.pop_front();
    n_chk++; if ({x_o, y_o, z_o} !== ea) begin n_fail++; $display("FAIL b2b_first_result: got %h want %h", {x_o, y_o, z_o}, ea); end
    @(posedge clk_i); #1;
    data_in_valid_strobe_i = 1'b0;
    exp_q.push_back(model(8'd40, 8'hE0, 8'd5, 1'b1));
    n_chk++; if (busy_o !== 1'b1 || data_out_valid_strobe_o !== 1'b0) begin n_fail++; $display("FAIL b2b_recapture: got busy=%b strobe=%b want 1/0", busy_o, data_out_valid_strobe_o); end
    repeat (3) @(posedge clk_i);
    #1;
    n_chk++; if ({x_o, y_o, z_o} !== ea) begin n_fail++; $display("FAIL b2b_hold_mid_calc: got %h want %h", {x_o, y_o, z_o}, ea); end
    wait_strobe(lat);
    n_chk++; if (lat !== LAT - 3) begin n_fail++; $display("FAIL b2b_second_latency: got %0d want %0d", lat + 3, LAT); end
    eb = exp_q.pop_front();
    n_chk++; if ({x_o, y_o, z_o} !== eb) begin n_fail++; $display("FAIL b2b_second_result: got %h want %h", {x_o, y_o, z_o}, eb); end
    @(posedge clk_i); #1;
  endtask

  task automatic test_reset_mid_calc;
    int   lat;
    bit   strobe_seen = 1'b0;
    res_t e;
    issue(8'd100, 8'd30, 8'd20, 1'b0);
    repeat (3) @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    #1;
    void'(exp_q.pop_back());
    n_chk++; if ({x_o, y_o, z_o} !== '0) begin n_fail++; $display("FAIL midrst_outputs: got %h want 0", {x_o, y_o, z_o}); end
    n_chk++; if (busy_o !== 1'b0 || ready_o !== 1'b1) begin n_fail++; $display("FAIL midrst_flags: got busy=%b ready=%b want 0/1", busy_o, ready_o); end
    for (int k = 0; k < 10; k++) begin
      if (data_out_valid_strobe_o !== 1'b0) strobe_seen = 1'b1;
      @(posedge clk_i); #1;
      if (k == 2) rst_i = 1'b1;
    end
    n_chk++; if (strobe_seen) begin n_fail++; $display("FAIL midrst_no_strobe: got strobe want none"); end
    rst_i = 1'b0;
    #2;
    rst_i = 1'b1;
    issue(8'd20, 8'd70, 8'hC0, 1'b0);
    wait_strobe(lat);
    e = exp_q.pop_front();
    n_chk++; if (lat !== LAT || {x_o, y_o, z_o} !== e) begin n_fail++; $display("FAIL midrst_fresh_op: got lat=%0d res=%h want lat=%0d res=%h", lat, {x_o, y_o, z_o}, LAT, e); end
    @(posedge clk_i); #1;
  endtask

  task automatic test_random;
    logic [W-1:0] ex [4] = '{8'h7F, 8'h80, 8'h7F, 8'h80};
    logic [W-1:0] ey [4] = '{8'h7F, 8'h80, 8'h80, 8'h7F};
    logic [W-1:0] ez [4] = '{8'h7F, 8'h80, 8'h00, 8'h7F};
    logic [W-1:0] rx, ry, rz;
    logic         rm;
    int           lat;
    res_t         e;
    for (int n = 0; n < N_RAND; n++) begin
      if (n < 4) begin
        rx = ex[n]; ry = ey[n]; rz = ez[n]; rm = n[0];
      end else begin
        rx = W'($urandom); ry = W'($urandom); rz = W'($urandom); rm = 1'($urandom);
      end
      issue(rx, ry, rz, rm);
      wait_strobe(lat);
      e = exp_q.pop_front();
      n_chk++;
      if (lat !== LAT || {x_o, y_o, z_o} !== e) begin
        n_fail++;
        $display("FAIL random_%0d: in=%h/%h/%h m=%b got lat=%0d res=%h want lat=%0d res=%h", n, rx, ry, rz, rm, lat, {x_o, y_o, z_o}, LAT, e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_reset_mid_calc();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
